// File: rtl/csr_file_m.sv
// rtl/csr_file_m.sv - machine-mode CSR file: Zicsr ops, traps, mret, cycle/instret counters
// Optional minstret counter enabled by defining CSR_MINSTRET_EN.
module csr_file_m #(
    parameter logic [31:0] MVENDORID = 32'h79737978,
    parameter logic [31:0] MARCHID   = 32'd25070198,
    parameter int          CNT_WIDTH = 64,
    parameter logic [31:0] MTVEC_RST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        instret_inc,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret,
    output logic [31:0] trap_vec,
    output logic [31:0] mepc_o
);
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;

    logic                 mie, mpie;
    logic [31:0]          mtvec, mepc, mcause;
    logic [CNT_WIDTH-1:0] mcycle;
    logic [63:0]          cyc64, cyc_nxt;
    logic [31:0]          mstatus_rd, wval;
    logic                 implemented, read_only, wants_write, wr_en;

    assign cyc64      = 64'(mcycle);
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
`ifdef CSR_MINSTRET_EN
    logic [CNT_WIDTH-1:0] minstret;
    logic [63:0]          ret64, ret_nxt;
    assign ret64 = 64'(minstret);
`else
    logic unused_instret;
    assign unused_instret = instret_inc;
`endif

    always_comb begin
        csr_rdata   = 32'h0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (csr_addr)
            A_MSTATUS:   csr_rdata = mstatus_rd;
            A_MTVEC:     csr_rdata = mtvec;
            A_MEPC:      csr_rdata = mepc;
            A_MCAUSE:    csr_rdata = mcause;
            A_MCYCLE:    csr_rdata = cyc64[31:0];
            A_MCYCLEH:   csr_rdata = cyc64[63:32];
`ifdef CSR_MINSTRET_EN
            A_MINSTRET:  csr_rdata = ret64[31:0];
            A_MINSTRETH: csr_rdata = ret64[63:32];
`endif
            A_MVENDORID: begin csr_rdata = MVENDORID; read_only = 1'b1; end
            A_MARCHID:   begin csr_rdata = MARCHID;   read_only = 1'b1; end
            default:     implemented = 1'b0;
        endcase
    end

    // RS/RC with a zero mask are pure reads, so they are legal on read-only CSRs
    assign wants_write = (csr_op == OP_RW) || (csr_wdata != 32'h0);
    assign csr_illegal = (csr_op != OP_NONE) && (!implemented || (read_only && wants_write));
    assign wr_en       = (csr_op != OP_NONE) && wants_write && !csr_illegal && !trap_valid;

    always_comb begin
        case (csr_op)
            OP_RW:   wval = csr_wdata;
            OP_RS:   wval = csr_rdata | csr_wdata;
            OP_RC:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_rdata;
        endcase
    end

    // Counters are computed 64 bits wide and truncated, which wraps at 2^CNT_WIDTH
    always_comb begin
        if (wr_en && csr_addr == A_MCYCLE)       cyc_nxt = {cyc64[63:32], wval};
        else if (wr_en && csr_addr == A_MCYCLEH) cyc_nxt = {wval, cyc64[31:0]};
        else                                     cyc_nxt = cyc64 + 64'd1;
    end
`ifdef CSR_MINSTRET_EN
    always_comb begin
        if (wr_en && csr_addr == A_MINSTRET)       ret_nxt = {ret64[63:32], wval};
        else if (wr_en && csr_addr == A_MINSTRETH) ret_nxt = {wval, ret64[31:0]};
        else if (instret_inc)                      ret_nxt = ret64 + 64'd1;
        else                                       ret_nxt = ret64;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle <= '0;
`ifdef CSR_MINSTRET_EN
            minstret <= '0;
`endif
            mtvec  <= MTVEC_RST;
            mepc   <= 32'h0;
            mcause <= 32'h0;
            mie    <= 1'b0;
            mpie   <= 1'b0;
        end else begin
            mcycle <= cyc_nxt[CNT_WIDTH-1:0];
`ifdef CSR_MINSTRET_EN
            minstret <= ret_nxt[CNT_WIDTH-1:0];
`endif
            if (trap_valid) begin
                mepc   <= {trap_pc[31:2], 2'b00};
                mcause <= trap_cause;
                mpie   <= mie;
                mie    <= 1'b0;
            end else begin
                if (wr_en) begin
                    case (csr_addr)
                        A_MSTATUS: begin mie <= wval[3]; mpie <= wval[7]; end
                        A_MTVEC:   mtvec  <= wval;
                        A_MEPC:    mepc   <= {wval[31:2], 2'b00};
                        A_MCAUSE:  mcause <= wval;
                        default:   ;
                    endcase
                end
                // mret is ordered after the CSR write so it owns MIE/MPIE
                if (mret) begin
                    mie  <= mpie;
                    mpie <= 1'b1;
                end
            end
        end
    end

    assign trap_vec = {mtvec[31:2], 2'b00};
    assign mepc_o   = mepc;
endmodule

// File: tb/tb_csr_file_m.sv
// tb/tb_csr_file_m.sv - directed self-checking bench for csr_file_m (64-bit and 40-bit counters)
module tb_csr_file_m;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h0;
    logic [31:0] csr_wdata = 32'h0;
    logic        instret_inc = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_cause = 32'h0;
    logic [31:0] trap_pc = 32'h0;
    logic        mret = 1'b0;
    logic [31:0] csr_rdata, trap_vec, mepc_o;
    logic        csr_illegal;
    logic [31:0] rdata40, trap_vec40, mepc40;
    logic        illegal40;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_file_m dut (
        .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .instret_inc(instret_inc),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret),
        .trap_vec(trap_vec), .mepc_o(mepc_o)
    );

    csr_file_m #(.CNT_WIDTH(40)) dut40 (
        .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(rdata40), .csr_illegal(illegal40), .instret_inc(instret_inc),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret),
        .trap_vec(trap_vec40), .mepc_o(mepc40)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_op = op;
        csr_addr = addr;
        csr_wdata = wd;
        #1;
    endtask

    task automatic rd(input logic [11:0] addr);
        drive(2'b00, addr, 32'h0);
    endtask

    initial begin
        #2;
        chk("rst_mcycle", dut.csr_rdata, 32'h0);
        rd(12'h300);
        chk("rst_mstatus", csr_rdata, 32'h0000_1800);
        chk("rst_trap_vec", trap_vec, 32'h0);
        chk("rst_mepc", mepc_o, 32'h0);
        step();
        step();
        rst = 1'b0;

        repeat (10) step();
        rd(12'hB00);
        chk("idle10_mcycle", csr_rdata, 32'd10);
        rd(12'hB80);
        chk("idle10_mcycleh", csr_rdata, 32'd0);
        rd(12'hF11);
        chk("mvendorid", csr_rdata, 32'h79737978);
        rd(12'hF12);
        chk("marchid", csr_rdata, 32'd25070198);
        rd(12'h300);
        chk("mstatus_idle", csr_rdata, 32'h0000_1800);

        drive(2'b01, 12'hB00, 32'hFFFF_FFFF);
        chk("mcycle_old_same_cycle", csr_rdata, 32'd10);
        chk("mcycle_wr_legal", {31'b0, csr_illegal}, 32'd0);
        step();
        rd(12'hB00);
        chk("mcycle_loaded", csr_rdata, 32'hFFFF_FFFF);
        step();
        chk("mcycle_carry_lo", csr_rdata, 32'h0);
        rd(12'hB80);
        chk("mcycle_carry_hi", csr_rdata, 32'h1);
        chk("mcycle40_carry_hi", rdata40, 32'h1);

        drive(2'b01, 12'hB00, 32'hFFFF_FFFF);
        step();
        drive(2'b01, 12'hB80, 32'h0000_00FF);
        step();
        rd(12'hB00);
        chk("mcycle40_max_lo", rdata40, 32'hFFFF_FFFF);
        rd(12'hB80);
        chk("mcycle40_max_hi", rdata40, 32'h0000_00FF);
        step();
        chk("mcycle40_wrap_hi", rdata40, 32'h0);
        chk("mcycle64_nowrap_hi", csr_rdata, 32'h0000_0100);
        rd(12'hB00);
        chk("mcycle40_wrap_lo", rdata40, 32'h0);

        drive(2'b10, 12'h300, 32'h8);
        step();
        rd(12'h300);
        chk("mstatus_rs_mie", csr_rdata, 32'h0000_1808);
        trap_valid = 1'b1; trap_cause = 32'd11; trap_pc = 32'h8000_0102;
        step();
        trap_valid = 1'b0;
        rd(12'h300);
        chk("trap_mepc", mepc_o, 32'h8000_0100);
        chk("trap_mstatus", csr_rdata, 32'h0000_1880);
        rd(12'h342);
        chk("trap_mcause", csr_rdata, 32'd11);
        mret = 1'b1;
        step();
        mret = 1'b0;
        rd(12'h300);
        chk("mret_mstatus", csr_rdata, 32'h0000_1888);

        trap_valid = 1'b1; trap_cause = 32'd2; trap_pc = 32'h0000_0100;
        drive(2'b01, 12'h305, 32'h1234);
        step();
        trap_valid = 1'b0;
        rd(12'h305);
        chk("trap_drops_mtvec", csr_rdata, 32'h0);
        chk("trap2_mepc", mepc_o, 32'h0000_0100);
        rd(12'h342);
        chk("trap2_mcause", csr_rdata, 32'd2);
        drive(2'b01, 12'h305, 32'h1237);
        step();
        rd(12'h305);
        chk("mtvec_stored", csr_rdata, 32'h1237);
        chk("trap_vec_aligned", trap_vec, 32'h1234);

        drive(2'b01, 12'hF11, 32'h5);
        chk("rw_ro_illegal", {31'b0, csr_illegal}, 32'd1);
        step();
        rd(12'hF11);
        chk("ro_unchanged", csr_rdata, 32'h79737978);
        drive(2'b10, 12'hF11, 32'h0);
        chk("rs0_ro_legal", {31'b0, csr_illegal}, 32'd0);
        drive(2'b11, 12'hF12, 32'h0);
        chk("rc0_ro_legal", {31'b0, csr_illegal}, 32'd0);
        drive(2'b01, 12'h123, 32'h1);
        chk("unimpl_illegal", {31'b0, csr_illegal}, 32'd1);

        drive(2'b01, 12'h300, 32'h0);
        mret = 1'b1;
        step();
        mret = 1'b0;
        rd(12'h300);
        chk("mret_beats_write", csr_rdata, 32'h0000_1888);
        drive(2'b01, 12'h341, 32'h0000_0203);
        step();
        chk("mepc_align", mepc_o, 32'h0000_0200);

`ifdef CSR_MINSTRET_EN
        rd(12'h0);
        instret_inc = 1'b1;
        repeat (5) step();
        instret_inc = 1'b0;
        rd(12'hB02);
        chk("minstret_5", csr_rdata, 32'd5);
        instret_inc = 1'b1;
        drive(2'b01, 12'hB02, 32'd100);
        step();
        instret_inc = 1'b0;
        rd(12'hB02);
        chk("minstret_wr_wins", csr_rdata, 32'd100);
`else
        instret_inc = 1'b1;
        drive(2'b10, 12'hB02, 32'h0);
        chk("minstret_absent_rd", csr_rdata, 32'h0);
        chk("minstret_absent_ill", {31'b0, csr_illegal}, 32'd1);
        step();
        instret_inc = 1'b0;
`endif

        rd(12'hB00);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_mcycle", csr_rdata, 32'h0);
        chk("async_rst_mepc", mepc_o, 32'h0);
        rd(12'h300);
        chk("async_rst_mstatus", csr_rdata, 32'h0000_1800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
- Parametrised machine-mode CSR file for the single-cycle NPC core; successor of the fixed cycle-counter/ID CSR block.
- Holds mstatus, mtvec, mepc, mcause, a CNT_WIDTH cycle counter, optional minstret, and read-only ID registers.
- Performs Zicsr RW/RS/RC atomically, takes ecall/exception traps, executes mret, and supplies the trap vector and return PC to the IFU.

Parameters:
- MVENDORID, 32'h79737978, value of mvendorid (0xF11)
- MARCHID, 32'd25070198, value of marchid (0xF12)
- CNT_WIDTH, 64, cycle/instret counter width; legal 33..64; bits above CNT_WIDTH read as 0
- MTVEC_RST, 32'h0, reset value of mtvec

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
- csr_addr  in  12  CSR address
- csr_wdata  in  32  rs1 value or zimm
- csr_rdata  out  32  combinational old value at csr_addr
- csr_illegal  out  1  combinational; csr_op!=0 and address unimplemented, or write to a read-only CSR
- instret_inc  in  1  one instruction retired this cycle
- trap_valid  in  1  take trap this cycle
- trap_cause  in  32  value for mcause
- trap_pc  in  32  PC of the trapping instruction
- mret  in  1  mret executing this cycle
- trap_vec  out  32  {mtvec[31:2],2'b00}, combinational
- mepc_o  out  32  current mepc, combinational

Behaviour:
- Reset (async assert, sync release): mcycle=0, minstret=0, mtvec=MTVEC_RST, mepc=0, mcause=0, mstatus=32'h0000_1800 (MPP=11). Outputs follow the reset state immediately.
- Address map:
  - 0x300 mstatus: MIE[3], MPIE[7] writable; MPP[12:11] hard-wired 11; other bits read 0.
  - 0x305 mtvec: all bits stored.
  - 0x341 mepc: bit[1:0] forced 0.
  - 0x342 mcause: all bits stored.
  - 0xB00/0xB80 mcycle/mcycleh.
  - 0xB02/0xB82 minstret/minstreth (optional).
  - 0xF11/0xF12 read-only.
- Write value: RW=wdata, RS=old|wdata, RC=old&~wdata. RS/RC with wdata==0 performs no write and raises no illegal for read-only CSRs.
- Write timing: takes effect at the next posedge; csr_rdata in the same cycle returns the old value.
- Illegal op: any state change suppressed, including the counter write; counters still increment.
- Counters:
  - mcycle increments by 1 every cycle out of reset, wrapping at 2^CNT_WIDTH to 0.
  - A write to the low or high half loads that half from the write value, keeps the other half, and suppresses that counter's increment for the cycle.
- Trap (trap_valid=1): next posedge sets mepc=trap_pc&~3, mcause=trap_cause, MPIE=MIE, MIE=0. Any CSR write in the same cycle is dropped.
- mret: next posedge sets MIE=MPIE, MPIE=1. If trap_valid and mret are both set, trap wins.
- mret with a CSR write to mstatus in the same cycle: mret update wins for MIE/MPIE.
- Reset asserted mid-operation discards any pending write or trap.

Optional Feature:
- Macro CSR_MINSTRET_EN.
- Defined: minstret counter present (CNT_WIDTH wide). It increments when instret_inc=1, wrapping at 2^CNT_WIDTH, with the same write-priority rule as mcycle. A CSR instruction writing minstret with instret_inc=1 loads the written value and does not increment.
- Undefined: 0xB02/0xB82 are unimplemented; reads return 0, csr_illegal=1, and instret_inc is ignored.

Test Plan:
- Reset, then 10 clocks idle -> read 0xB00 = 10, 0xB80 = 0, 0xF11 = 0x79737978, 0xF12 = 25070198, mstatus = 0x1800.
- RW 0xB00 with 0xFFFFFFFF, then idle 1 cycle -> mcycleh=1, mcycle=0 (carry across halves). CNT_WIDTH=40 with mcycle=2^40-1 -> wraps to 0, mcycleh reads 0.
- RS mstatus with 0x8 -> MIE=1. trap_valid, cause=11, pc=0x80000102 -> mepc=0x80000100, mcause=11, MIE=0, MPIE=1. mret -> MIE=1, MPIE=1.
- Same cycle: trap_valid and RW mtvec=0x1234 -> mtvec unchanged, trap taken. RW 0xF11 -> csr_illegal=1, value unchanged. RS 0xF11 with wdata 0 -> csr_illegal=0.
- With CSR_MINSTRET_EN: 5 cycles of instret_inc -> minstret=5. RW minstret=100 with instret_inc=1 -> 100. Without the macro: read 0xB02 -> 0, csr_illegal=1.
- Assert rst asynchronously mid-cycle, with no clock edge -> mcycle=0 and mepc=0 immediately.
